// File: rtl/reg_file_pkg.sv
// Shared processor constants and types for the integer register file.
package reg_file_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]   xlen_t;

endpackage

// File: rtl/reg_file_register.sv
// One architectural register: loads data_i when WriteEn is high, clears on synchronous reset.
module reg_file_register
  import reg_file_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             WriteEn,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (WriteEn) data_d = data_i;
  end

  // Reset wins over a simultaneous write so no partial write survives.
  always_ff @(posedge clk) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/reg_file.sv
// Two-read, one-write register file with x0 hardwired to zero and a WB->ID
// write-before-read bypass on both read ports.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int XLEN   = reg_file_pkg::XLEN,
  parameter int NREGS  = reg_file_pkg::NREGS,
  parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [XLEN-1:0]   WriteData,
  input  logic              RegWrite,
  output logic [XLEN-1:0]   ReadData1,
  output logic [XLEN-1:0]   ReadData2
);

  logic [NREGS-1:0] writeEn;
  logic [XLEN-1:0]  regVal [NREGS];
  logic             bypassValid;

  always_comb begin
    writeEn = '0;
    if (RegWrite) writeEn[WriteReg] = 1'b1;
    writeEn[0] = 1'b0;
  end

  assign regVal[0] = '0;

  for (genvar i = 1; i < NREGS; i++) begin : gRegs
    reg_file_register #(
      .WIDTH (XLEN)
    ) uReg (
      .clk     (clk),
      .reset   (reset),
      .WriteEn (writeEn[i]),
      .data_i  (WriteData),
      .data_o  (regVal[i])
    );
  end

  // Bypass is suppressed while reset is asserted: the write will not land.
  assign bypassValid = RegWrite && !reset && (WriteReg != '0);

  always_comb begin
    ReadData1 = regVal[ReadReg1];
    if (bypassValid && (WriteReg == ReadReg1)) ReadData1 = WriteData;
    if (ReadReg1 == '0) ReadData1 = '0;

    ReadData2 = regVal[ReadReg2];
    if (bypassValid && (WriteReg == ReadReg2)) ReadData2 = WriteData;
    if (ReadReg2 == '0) ReadData2 = '0;
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_reg_file;

  logic        clk;
  logic        reset;
  logic [4:0]  ReadReg1, ReadReg2, WriteReg;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [31:0] ReadData1, ReadData2;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];
  logic [31:0] obs1, obs2;

  reg_file dut (
    .clk       (clk),
    .reset     (reset),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .RegWrite  (RegWrite),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // A read sees the pending write if it is enabled, not to x0, and not under reset.
  function automatic logic [31:0] expectedRead(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (RegWrite && !reset && WriteReg == idx) return WriteData;
    return model[idx];
  endfunction

  task automatic applyStimulus(input logic rst, input logic we, input logic [4:0] wr,
                               input logic [31:0] wd, input logic [4:0] r1,
                               input logic [4:0] r2, input bit doCheck);
    @(negedge clk);
    reset = rst; RegWrite = we; WriteReg = wr; WriteData = wd;
    ReadReg1 = r1; ReadReg2 = r2;
    #1;
    obs1 = ReadData1;
    obs2 = ReadData2;
    if (doCheck) begin
      checkOutput($sformatf("rd1[x%0d]", r1), obs1, expectedRead(r1));
      checkOutput($sformatf("rd2[x%0d]", r2), obs2, expectedRead(r2));
    end
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 32; k++) model[k] = 32'h0;
    end else if (we && wr != 0) begin
      model[wr] = wd;
    end
  endtask

  initial begin
    reset = 1'b1; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    ReadReg1 = '0; ReadReg2 = '0;
    for (int k = 0; k < 32; k++) model[k] = 32'h0;

    // Stored contents are unknown before the first reset edge.
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);

    // Reset overrides a simultaneous write to x5.
    applyStimulus(1'b1, 1'b1, 5'd5, 32'hFFFF_FFFF, 5'd5, 5'd5, 1'b1);
    checkOutput("reset_nobypass", obs1, 32'h0);
    for (int i = 0; i < 32; i += 2) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i + 1), 1'b1);
      checkOutput("after_reset_even", obs1, 32'h0);
      checkOutput("after_reset_odd", obs2, 32'h0);
    end

    // Write disabled: nothing stored, nothing bypassed.
    applyStimulus(1'b0, 1'b0, 5'd9, 32'hAAAA_AAAA, 5'd9, 5'd9, 1'b1);
    checkOutput("wdis_same_cycle", obs1, 32'h0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b1);
    checkOutput("wdis_next_cycle", obs1, 32'h0);

    // Basic write then read on both ports.
    applyStimulus(1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b1);
    checkOutput("x7_port1", obs1, 32'hDEAD_BEEF);
    checkOutput("x7_port2", obs2, 32'hDEAD_BEEF);

    // x0 immunity.
    applyStimulus(1'b0, 1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 1'b1);
    checkOutput("x0_write_cycle", obs1, 32'h0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b1);
    checkOutput("x0_later", obs1, 32'h0);

    // Bypass on port 1 only, port 2 reads the stored x4.
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h1111_1111, 5'd0, 5'd0, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'd4, 32'h4444_4444, 5'd3, 5'd0, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h2222_2222, 5'd3, 5'd4, 1'b1);
    checkOutput("bypass_port1", obs1, 32'h2222_2222);
    checkOutput("bypass_port2_old", obs2, 32'h4444_4444);
    applyStimulus(1'b0, 1'b1, 5'd6, 32'h6666_6666, 5'd6, 5'd6, 1'b1);
    checkOutput("bypass_both1", obs1, 32'h6666_6666);
    checkOutput("bypass_both2", obs2, 32'h6666_6666);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b1);
    checkOutput("x3_after_write", obs1, 32'h2222_2222);

    // Sweep all registers, then read mirrored pairs.
    for (int i = 1; i < 32; i++)
      applyStimulus(1'b0, 1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'd0, 5'd0, 1'b1);
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i), 1'b1);
      checkOutput("sweep_p1", obs1, 32'(i) * 32'h0101_0101);
      checkOutput("sweep_p2", obs2, 32'(32 - i) * 32'h0101_0101);
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd31, 1'b1);
    checkOutput("sweep_x0", obs1, 32'h0);

    // Randomized traffic, including mid-sequence resets.
    for (int n = 0; n < 600; n++) begin
      logic        rst, we;
      logic [4:0]  wr, r1, r2;
      logic [31:0] wd;
      rst = ($urandom_range(0, 39) == 0);
      we  = ($urandom_range(0, 9) < 7);
      wr  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      r1  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      r2  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      applyStimulus(rst, we, wr, wd, r1, r2, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
